// File: rtl/ln_successive_approx.sv
// ---------------------------------------------------------------------------
// ln_successive_approx
//
// Sequential fixed-point natural logarithm, the inverse of the combinational
// e^x table. For a signed Q(W-F).F operand y it returns the largest signed
// x with exp_tab(x) <= y. The search is a W-step bisection over an internal
// exp table that is built at elaboration time.
//
// The search runs on an offset-binary register u, where x = u ^ sign_bit.
// Offset binary is also the table index, so a trial value addresses the
// table directly without any sign conversion.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    y_in is valid
//   in_ready    block can accept y_in (IDLE only)
//   y_in        signed fixed-point operand
//   out_valid   x_out and flags are valid; held until out_ready
//   out_ready   consumer accepts the result
//   x_out       signed fixed-point ln result
//   domain_err  the operand was <= 0
//   underflow   the operand was > 0 but below exp_tab(-2^(W-1))
// ---------------------------------------------------------------------------
`ifndef TOTAL_BITS
`define TOTAL_BITS 8
`endif
`ifndef FX_BITS
`define FX_BITS 4
`endif

module ln_successive_approx #(
    parameter int W = `TOTAL_BITS,
    parameter int F = `FX_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] y_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] x_out,
    output logic                domain_err,
    output logic                underflow
);

    localparam int BW = $clog2(W);

    localparam logic [W-1:0] SIGN_BIT = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONE_W    = {{(W-1){1'b0}}, 1'b1};

    // Fixed-point constants for building the table. e^|x| is evaluated in
    // Q32 with a Taylor series; the series stops early once the running sum
    // proves the entry saturates (positive x) or truncates to 0 (negative x).
    localparam longint ONE_Q32 = longint'(1) <<< 32;
    localparam longint SCALE   = longint'(1) <<< F;
    localparam longint TAB_MAX = (longint'(1) <<< (W - 1)) - 1;
    localparam longint TAB_MIN = -(longint'(1) <<< (W - 1));
    localparam longint CAP_POS = ((TAB_MAX + 1) <<< 32) / SCALE;
    localparam longint CAP_NEG = (SCALE <<< 32) + 1;

    // e^(a / 2^F) in Q32 for a >= 0, cut short once the sum reaches cap.
    function automatic longint exp_q32(input longint a, input longint cap);
        longint term;
        longint sum;
        bit     done;
        term = ONE_Q32;
        sum  = ONE_Q32;
        done = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (!done) begin
                term = (term * a) / (SCALE * k);
                sum  = sum + term;
                if (term == 0 || sum >= cap) begin
                    done = 1'b1;
                end
            end
        end
        return sum;
    endfunction

    // Clamp a table value to the signed W-bit range.
    function automatic logic signed [W-1:0] sat_tab(input longint v);
        longint c;
        c = v;
        if (c > TAB_MAX) begin
            c = TAB_MAX;
        end
        if (c < TAB_MIN) begin
            c = TAB_MIN;
        end
        return c[W-1:0];
    endfunction

    // floor(e^(i/2^F) * 2^F), saturated. Negative i uses 2^F / e^|x| so the
    // series never has to deal with alternating-sign cancellation.
    function automatic logic signed [W-1:0] exp_entry(input int i);
        longint s;
        longint v;
        if (i >= 0) begin
            s = exp_q32(longint'(i), CAP_POS);
            v = (s >= CAP_POS) ? (TAB_MAX + 1) : ((s * SCALE) >>> 32);
        end else begin
            s = exp_q32(-longint'(i), CAP_NEG);
            v = (SCALE <<< 32) / s;
        end
        return sat_tab(v);
    endfunction

    // Table indexed by offset-binary x (index 0 is x = -2^(W-1)).
    logic signed [W-1:0] exp_tab [2**W];

    for (genvar g = 0; g < 2**W; g++) begin : g_tab
        localparam logic signed [W-1:0] TAB_VAL = exp_entry(g - 2**(W-1));
        assign exp_tab[g] = TAB_VAL;
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [W-1:0] y_reg;
    logic        [W-1:0] u;
    logic       [BW-1:0] b;

    logic                y_nonpos;
    logic        [W-1:0] bit_mask;
    logic        [W-1:0] trial;
    logic signed [W-1:0] trial_val;
    logic                take;
    logic        [W-1:0] u_next;

    // Sign bit or all-zero: avoids mixing a signed operand with an unsigned
    // literal, which would turn the comparison unsigned.
    assign y_nonpos = y_in[W-1] | ~(|y_in);

    // One bisection step: try setting bit b and keep it if the table entry
    // at the trial point still does not exceed y.
    always_comb begin
        bit_mask  = ONE_W << b;
        trial     = u | bit_mask;
        trial_val = exp_tab[trial];
        take      = (trial_val <= y_reg);
        u_next    = take ? trial : u;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = y_nonpos ? ST_DONE : ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (b == '0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg      <= '0;
            u          <= '0;
            b          <= '0;
            x_out      <= '0;
            domain_err <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        y_reg     <= y_in;
                        u         <= '0;
                        b         <= BW'(W - 1);
                        underflow <= 1'b0;
                        if (y_nonpos) begin
                            x_out      <= SIGN_BIT;
                            domain_err <= 1'b1;
                        end else begin
                            domain_err <= 1'b0;
                        end
                    end
                end
                ST_SEARCH: begin
                    u <= u_next;
                    if (b == '0) begin
                        x_out     <= u_next ^ SIGN_BIT;
                        // u stuck at 0 is ambiguous: either the most negative
                        // x is the genuine answer or even it is too large.
                        underflow <= (u_next == '0) && (exp_tab[0] > y_reg);
                    end else begin
                        b <= b - BW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ln_successive_approx.sv
module tb_ln_successive_approx;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] y_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] x_out;
    logic       domain_err;
    logic       underflow;

    int checks;
    int errors;

    int model_tab [256];

    typedef struct {
        logic [7:0] y;
        logic [7:0] x;
        logic       de;
        logic       uf;
        int         stall;
    } vec_t;

    vec_t vecs [9];

    ln_successive_approx #(.W(8), .F(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .y_in       (y_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .x_out      (x_out),
        .domain_err (domain_err),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Complete the output handshake and confirm the block returns to IDLE.
    task automatic finish_op(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_ov_clear"}, out_valid, 1'b0);
        check({name, "_in_ready_back"}, in_ready, 1'b1);
    endtask

    // Issue one operand, check latency, result, flags, hold under stall.
    task automatic run_op(input string name, input logic [7:0] y, input logic [7:0] ex,
                          input logic ede, input logic euf, input int stall);
        int n;
        int lat;
        int exp_lat;
        exp_lat = ($signed(y) <= 0) ? 0 : 8;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_in_ready"}, in_ready, 1'b1);
        in_valid = 1'b1;
        y_in     = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        y_in     = 8'hA5;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_x"}, x_out, ex);
        check({name, "_de"}, domain_err, ede);
        check({name, "_uf"}, underflow, euf);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            check({name, "_hold_ov"}, out_valid, 1'b1);
            check({name, "_hold_x"}, x_out, ex);
            check({name, "_hold_de"}, domain_err, ede);
            check({name, "_hold_in_ready"}, in_ready, 1'b0);
        end
        finish_op(name);
    endtask

    task automatic model(input logic [7:0] y, output logic [7:0] x, output logic de,
                         output logic uf);
        int ys;
        int best;
        ys = $signed(y);
        de = 1'b0;
        uf = 1'b0;
        x  = 8'h80;
        if (ys <= 0) begin
            de = 1'b1;
        end else begin
            best = -1;
            for (int i = 0; i < 256; i++) begin
                if (model_tab[i] <= ys) best = i;
            end
            if (best < 0) uf = 1'b1;
            else x = best[7:0] ^ 8'h80;
        end
    endtask

    initial begin
        int lat;
        logic [7:0] mx;
        logic       mde;
        logic       muf;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        y_in      = 8'h00;

        for (int i = 0; i < 256; i++) begin
            real r;
            int  v;
            r = $exp(real'(i - 128) / 16.0) * 16.0;
            v = $rtoi(r);
            if (v > 127) v = 127;
            model_tab[i] = v;
        end

        vecs[0] = '{y: 8'h10, x: 8'h00, de: 1'b0, uf: 1'b0, stall: 0};
        vecs[1] = '{y: 8'h2B, x: 8'h10, de: 1'b0, uf: 1'b0, stall: 1};
        vecs[2] = '{y: 8'h01, x: 8'hDE, de: 1'b0, uf: 1'b0, stall: 2};
        vecs[3] = '{y: 8'h7F, x: 8'h7F, de: 1'b0, uf: 1'b0, stall: 5};
        vecs[4] = '{y: 8'h00, x: 8'h80, de: 1'b1, uf: 1'b0, stall: 0};
        vecs[5] = '{y: 8'hFB, x: 8'h80, de: 1'b1, uf: 1'b0, stall: 3};
        vecs[6] = '{y: 8'h08, x: 8'hF6, de: 1'b0, uf: 1'b0, stall: 1};
        vecs[7] = '{y: 8'h20, x: 8'h0B, de: 1'b0, uf: 1'b0, stall: 0};
        vecs[8] = '{y: 8'h80, x: 8'h80, de: 1'b1, uf: 1'b0, stall: 2};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_x", x_out, 8'h00);
        check("rst_de", domain_err, 1'b0);
        check("rst_uf", underflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].y, vecs[i].x, vecs[i].de, vecs[i].uf,
                   vecs[i].stall);
        end

        // in_valid pulses during SEARCH must be ignored
        @(negedge clk);
        in_valid = 1'b1;
        y_in     = 8'h2B;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (lat == 3 || lat == 4) begin
                in_valid = 1'b1;
                y_in     = 8'h7F;
                check("ign_in_ready_low", in_ready, 1'b0);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        check("ign_latency", lat, 8);
        check("ign_x", x_out, 8'h10);
        check("ign_de", domain_err, 1'b0);
        finish_op("ign");
        check("ign_no_second", out_valid, 1'b0);

        // Asynchronous reset mid-search (b == 3 after four search edges)
        @(negedge clk);
        in_valid = 1'b1;
        y_in     = 8'h20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ov", out_valid, 1'b0);
        check("arst_x", x_out, 8'h00);
        check("arst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            check("arst_no_output", out_valid, 1'b0);
        end
        run_op("after_rst", 8'h10, 8'h00, 1'b0, 1'b0, 0);

        // Exhaustive sweep against the real-valued model
        for (int y = 0; y < 256; y++) begin
            logic [7:0] yv;
            yv = y[7:0];
            model(yv, mx, mde, muf);
            run_op($sformatf("sweep_%02h", yv), yv, mx, mde, muf, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
